// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
// One request per cycle on a valid/ready port, one registered response per accepted request.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory for the MEM stage: RV32 B/H/W loads and stores, 1-cycle response,
// error flagging, and a post-reset clear sequencer that zeroes (or preloads) every word.
module data_mem_ctrl #(
    parameter int          DEPTH          = 1024,
    parameter int          ADDR_W         = 32,
    parameter int          CLEAR_ON_RESET = 1,
    parameter int          PRELOAD_EN     = 1,
    parameter int          PRELOAD_IDX    = 7,
    parameter logic [31:0] PRELOAD_VAL    = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_ctrl_if.slave   bus,
    output logic             init_done
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
    logic             init_done_q, init_done_d;

    logic             accept;
    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_off;
    logic             req_oor;
    logic             req_err;
    logic [3:0]       store_be;
    logic [31:0]      store_data;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             rsp_load_q;
    logic [1:0]       rsp_size_q;
    logic             rsp_unsigned_q;
    logic [1:0]       rsp_off_q;
    logic [31:0]      rd_word;
    logic [31:0]      rsp_rdata;

    // Request decode
    assign accept  = bus.req_valid && bus.req_ready && rst_n;
    assign req_idx = bus.req_addr[IDX_W+1:2];
    assign req_off = bus.req_addr[1:0];
    assign req_oor = |bus.req_addr[ADDR_W-1:IDX_W+2];
    assign req_err = (bus.req_size == 2'b11)
                   | ((bus.req_size == 2'b01) && req_off[0])
                   | ((bus.req_size == 2'b10) && (req_off != 2'b00))
                   | req_oor;

    // Stores are replicated across lanes; the byte enables pick which lanes actually land.
    always_comb begin
        store_be   = 4'b0000;
        store_data = 32'h0;
        case (bus.req_size)
            2'b00: begin
                store_be   = 4'b0001 << req_off;
                store_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                store_be   = 4'b0011 << req_off;
                store_data = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                store_be   = 4'b1111;
                store_data = bus.req_wdata;
            end
            default: begin
                store_be   = 4'b0000;
                store_data = 32'h0;
            end
        endcase
    end

    // Next-state logic and the single memory write port shared by clear and store traffic
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        init_done_d = init_done_q;
        wr_en       = 1'b0;
        wr_idx      = req_idx;
        wr_be       = 4'b0000;
        wr_data     = 32'h0;
        case (state_q)
            ST_INIT: begin
                wr_en     = 1'b1;
                wr_idx    = clr_ptr_q;
                wr_be     = 4'b1111;
                wr_data   = ((PRELOAD_EN != 0) && (int'(clr_ptr_q) == PRELOAD_IDX)) ? PRELOAD_VAL : 32'h0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            ST_READY: begin
                if (accept && bus.req_we && !req_err) begin
                    wr_en   = 1'b1;
                    wr_be   = store_be;
                    wr_data = store_data;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    assign bus.req_ready = (state_q == ST_READY);

    // One byte-wide RAM per lane, each with a registered read of the requested word
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_byte_q;

        always_ff @(posedge clk) begin
            if (wr_en && rst_n && wr_be[gi]) begin
                mem_q[wr_idx] <= wr_data[gi*8 +: 8];
            end
            rd_byte_q <= mem_q[req_idx];
        end

        assign rd_word[gi*8 +: 8] = rd_byte_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
            clr_ptr_q      <= '0;
            init_done_q    <= (CLEAR_ON_RESET == 0);
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_load_q     <= 1'b0;
            rsp_size_q     <= 2'b00;
            rsp_unsigned_q <= 1'b0;
            rsp_off_q      <= 2'b00;
        end else begin
            state_q        <= state_d;
            clr_ptr_q      <= clr_ptr_d;
            init_done_q    <= init_done_d;
            rsp_valid_q    <= accept;
            rsp_err_q      <= accept && req_err;
            rsp_load_q     <= accept && !bus.req_we && !req_err;
            rsp_size_q     <= bus.req_size;
            rsp_unsigned_q <= bus.req_unsigned;
            rsp_off_q      <= req_off;
        end
    end

    // Lane extraction and extension act only on registered state, so the output stays 0 unless a load responds.
    always_comb begin
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        sel_b     = rd_word[{rsp_off_q, 3'b000} +: 8];
        sel_h     = rd_word[{rsp_off_q[1], 4'b0000} +: 16];
        rsp_rdata = 32'h0;
        if (rsp_load_q) begin
            case (rsp_size_q)
                2'b00:   rsp_rdata = rsp_unsigned_q ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
                2'b01:   rsp_rdata = rsp_unsigned_q ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
                2'b10:   rsp_rdata = rd_word;
                default: rsp_rdata = 32'h0;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata;
    assign init_done     = init_done_q;

endmodule
